// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control FSM for the picoMIPS datapath.
// Sequences each instruction as FETCH then EXEC, with switch-handshake wait
// states for IN and a terminal HALT.
//
// Optional build macro STEP_MODE_EN adds a 'step' push-button input. With it,
// FETCH waits for a debounced rising edge of step, which gives
// single-instruction stepping.
//
// state        | meaning
// -------------+------------------------------------------------------------
// FETCH        | ROM opcode settling; no outputs; holds here until step (step mode)
// EXEC         | decode held opcode and drive datapath controls for one cycle
// WAIT_PRESS   | IN with hold_en: wait for debounced switch = 1, then write once
// WAIT_RELEASE | wait for debounced switch = 0, then advance the PC once
// HALT         | absorbing; halted = 1 until reset
module instr_sequencer #(
    parameter int DB_CYCLES = 3,
    parameter int DB_W      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic       hold_en,
    input  logic       sw_raw,
`ifdef STEP_MODE_EN
    input  logic       step,
`endif
    output logic       pc_en,
    output logic       pc_branch,
    output logic       w,
    output logic       write_select,
    output logic       imm,
    output logic       func,
    output logic       led_load,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_FETCH        = 3'd0,
        S_EXEC         = 3'd1,
        S_WAIT_PRESS   = 3'd2,
        S_WAIT_RELEASE = 3'd3,
        S_HALT         = 3'd4
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_MULI = 3'b100;
    localparam logic [2:0] OP_IN   = 3'b101;
    localparam logic [2:0] OP_BR   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // The debounced value flips on the sample that completes the run.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    state_t          state;
    state_t          state_next;

    logic            sw_meta;
    logic            sw_sync;
    logic            sw_db;
    logic [DB_W-1:0] sw_cnt;
    logic            step_go;

    // Two-flop synchroniser for the asynchronous switch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta <= 1'b0;
            sw_sync <= 1'b0;
        end else begin
            sw_meta <= sw_raw;
            sw_sync <= sw_meta;
        end
    end

    // Switch debounce: a run of differing samples flips the value, any matching sample restarts the run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_db  <= 1'b0;
            sw_cnt <= '0;
        end else if (sw_sync == sw_db) begin
            sw_cnt <= '0;
        end else if (sw_cnt == DB_LAST) begin
            sw_db  <= sw_sync;
            sw_cnt <= '0;
        end else begin
            sw_cnt <= sw_cnt + 1'b1;
        end
    end

`ifdef STEP_MODE_EN
    logic            step_meta;
    logic            step_sync;
    logic            step_db;
    logic            step_db_d;
    logic [DB_W-1:0] step_cnt;

    // Two-flop synchroniser for the step button.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
        end else begin
            step_meta <= step;
            step_sync <= step_meta;
        end
    end

    // Step debounce, plus a delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_db   <= 1'b0;
            step_db_d <= 1'b0;
            step_cnt  <= '0;
        end else begin
            step_db_d <= step_db;
            if (step_sync == step_db) begin
                step_cnt <= '0;
            end else if (step_cnt == DB_LAST) begin
                step_db  <= step_sync;
                step_cnt <= '0;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    // A rising edge seen outside FETCH is simply dropped.
    assign step_go = step_db & ~step_db_d;
`else
    assign step_go = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH: begin
                if (step_go) state_next = (opcode == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_next = (opcode == OP_IN && hold_en) ? S_WAIT_PRESS : S_FETCH;
            end
            S_WAIT_PRESS: begin
                if (sw_db) state_next = S_WAIT_RELEASE;
            end
            S_WAIT_RELEASE: begin
                if (!sw_db) state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Output decode from state, held opcode and debounced switch; FETCH drives nothing.
    always_comb begin
        pc_en        = 1'b0;
        pc_branch    = 1'b0;
        w            = 1'b0;
        write_select = 1'b0;
        imm          = 1'b0;
        func         = 1'b0;
        led_load     = 1'b0;
        halted       = 1'b0;
        unique case (state)
            S_EXEC: begin
                unique case (opcode)
                    OP_NOP: begin
                        pc_en = 1'b1;
                    end
                    OP_ADD: begin
                        w     = 1'b1;
                        pc_en = 1'b1;
                    end
                    OP_ADDI: begin
                        w        = 1'b1;
                        imm      = 1'b1;
                        led_load = 1'b1;
                        pc_en    = 1'b1;
                    end
                    OP_MUL: begin
                        w     = 1'b1;
                        func  = 1'b1;
                        pc_en = 1'b1;
                    end
                    OP_MULI: begin
                        w     = 1'b1;
                        imm   = 1'b1;
                        func  = 1'b1;
                        pc_en = 1'b1;
                    end
                    OP_IN: begin
                        w            = ~hold_en;
                        write_select = ~hold_en;
                        pc_en        = ~hold_en;
                    end
                    OP_BR: begin
                        pc_branch = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            S_WAIT_PRESS: begin
                w            = sw_db;
                write_select = sw_db;
            end
            S_WAIT_RELEASE: begin
                pc_en = ~sw_db;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios followed by a
// randomized instruction stream, checked against an instruction-level model.
module tb_instr_sequencer;

    localparam int DB = 3;

    localparam logic [7:0] B_PC   = 8'h01;
    localparam logic [7:0] B_BR   = 8'h02;
    localparam logic [7:0] B_W    = 8'h04;
    localparam logic [7:0] B_WS   = 8'h08;
    localparam logic [7:0] B_IMM  = 8'h10;
    localparam logic [7:0] B_FUNC = 8'h20;
    localparam logic [7:0] B_LED  = 8'h40;
    localparam logic [7:0] B_HALT = 8'h80;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       hold_en = 1'b0;
    logic       sw_raw = 1'b0;
`ifdef STEP_MODE_EN
    logic       step = 1'b0;
`endif
    logic pc_en, pc_branch, w, write_select, imm, func, led_load, halted;
    logic [7:0] outs;

    assign outs = {halted, led_load, func, imm, write_select, w, pc_branch, pc_en};

    always #5 clk = ~clk;

    instr_sequencer #(.DB_CYCLES(DB), .DB_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .hold_en      (hold_en),
        .sw_raw       (sw_raw),
`ifdef STEP_MODE_EN
        .step         (step),
`endif
        .pc_en        (pc_en),
        .pc_branch    (pc_branch),
        .w            (w),
        .write_select (write_select),
        .imm          (imm),
        .func         (func),
        .led_load     (led_load),
        .halted       (halted)
    );

    int checks = 0;
    int errors = 0;

    // Model state: raw input history feeding an abstract debounce per input (0 = sw, 1 = step).
    logic [1:0] hist[$];
    logic       m_db[2];
    int         m_cnt[2];
    logic       m_step_prev;
    int         cyc = 0;
    int         rise_cyc = 0;
    int         fall_cyc = 0;
    int         w_cyc = 0;
    int         pc_cyc = 0;
    logic       last_sw = 1'b0;
    bit         rand_sw = 1'b0;
    bit         sw_script[$];
    int         wcnt, pccnt;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 2; k++) begin
            m_db[k]  = 1'b0;
            m_cnt[k] = 0;
        end
        m_step_prev = 1'b0;
    endtask

    // Expected EXEC outputs, straight from the opcode table.
    function automatic logic [7:0] exec_vec(input logic [2:0] op, input logic hold);
        logic [7:0] v;
        v = 8'h00;
        if (op >= 3'd1 && op <= 3'd4) v = v | B_W | B_PC;
        if (op == 3'd3 || op == 3'd4) v = v | B_FUNC;
        if (op == 3'd2 || op == 3'd4) v = v | B_IMM;
        if (op == 3'd2)               v = v | B_LED;
        if (op == 3'd0)               v = v | B_PC;
        if (op == 3'd6)               v = v | B_BR;
        if (op == 3'd5 && !hold)      v = v | B_W | B_WS | B_PC;
        return v;
    endfunction

    // One clock: record raw inputs, advance to just after the edge, update debounced model values.
    task automatic tick();
        logic [1:0] e;
        logic       s;
`ifdef STEP_MODE_EN
        hist.push_back({step, sw_raw});
`else
        hist.push_back({1'b0, sw_raw});
`endif
        if (hist.size() > 3) void'(hist.pop_front());
        if (sw_raw && !last_sw) rise_cyc = cyc;
        if (!sw_raw && last_sw) fall_cyc = cyc;
        last_sw = sw_raw;
        @(posedge clk);
        #1;
        cyc++;
        m_step_prev = m_db[1];
        for (int k = 0; k < 2; k++) begin
            s = 1'b0;
            if (hist.size() == 3) begin
                e = hist[0];
                s = e[k];
            end
            if (s != m_db[k]) begin
                m_cnt[k]++;
                if (m_cnt[k] == DB) begin
                    m_db[k]  = s;
                    m_cnt[k] = 0;
                end
            end else begin
                m_cnt[k] = 0;
            end
        end
    endtask

    task automatic drive_sw();
        if (sw_script.size() > 0) sw_raw = sw_script.pop_front();
        else if (rand_sw && $urandom_range(3) == 0) sw_raw = ~sw_raw;
    endtask

    task automatic look(input string tag, input logic [7:0] e);
        chk(tag, outs, e);
        chk("pc_excl", {7'd0, pc_en & pc_branch}, 8'd0);
        wcnt  += int'(w);
        pccnt += int'(pc_en);
    endtask

    // Run one instruction starting in FETCH; returns with the DUT back in FETCH (or in HALT).
    task automatic run_instr(input logic [2:0] op, input logic hold);
        int  guard;
        bit  pressed;
        bit  done;
        wcnt    = 0;
        pccnt   = 0;
        opcode  = op;
        hold_en = hold;
`ifdef STEP_MODE_EN
        guard = 0;
        while (!(m_db[1] && !m_step_prev) && guard < 100) begin
            look("fetch_idle", 8'h00);
            step = m_db[1] ? 1'b0 : 1'b1;
            drive_sw();
            tick();
            guard++;
        end
        if (guard >= 100) chk("step_timeout", 8'd1, 8'd0);
`endif
        look("fetch", 8'h00);
        drive_sw();
        tick();
        if (op == 3'd7) begin
            chk("halt_entry", outs, B_HALT);
            return;
        end
        look("exec", exec_vec(op, hold));
        drive_sw();
        tick();
        if (op == 3'd5 && hold) begin
            pressed = 1'b0;
            done    = 1'b0;
            guard   = 0;
            while (!done && guard < 300) begin
                if (!pressed) begin
                    if (m_db[0]) begin
                        look("press_pulse", B_W | B_WS);
                        w_cyc   = cyc;
                        pressed = 1'b1;
                    end else begin
                        look("press_wait", 8'h00);
                    end
                end else begin
                    if (!m_db[0]) begin
                        look("release_pulse", B_PC);
                        pc_cyc = cyc;
                        done   = 1'b1;
                    end else begin
                        look("release_wait", 8'h00);
                    end
                end
                drive_sw();
                tick();
                guard++;
            end
            if (!done) chk("wait_timeout", 8'd0, 8'd1);
        end
        chk("w_count", 8'(wcnt), (op >= 3'd1 && op <= 3'd5) ? 8'd1 : 8'd0);
        chk("pc_count", 8'(pccnt), (op == 3'd6) ? 8'd0 : 8'd1);
    endtask

    initial begin
        int start;
        model_reset();

        // Reset state.
        #2;
        chk("reset_outs", outs, 8'h00);
        #10;
        reset = 1'b1;

        // Reset asserted in the middle of ADD's EXEC cycle.
        opcode  = 3'd1;
        hold_en = 1'b0;
        chk("add_fetch", outs, 8'h00);
        tick();
        chk("add_exec", outs, B_W | B_PC);
        reset = 1'b0;
        #1;
        chk("rst_mid_exec", outs, 8'h00);
        #1;
        reset = 1'b1;
        model_reset();
        chk("rst_release", outs, 8'h00);
        run_instr(3'd1, 1'b0);

        // ADDI, MULI, MUL back to back, two cycles each.
        start = cyc;
        run_instr(3'd2, 1'b0);
        run_instr(3'd4, 1'b0);
        run_instr(3'd3, 1'b0);
`ifndef STEP_MODE_EN
        chk("instr_len", 8'(cyc - start), 8'd6);
`endif

        // IN with handshake: long low, clean press, clean release.
        for (int i = 0; i < 20; i++) sw_script.push_back(1'b0);
        for (int i = 0; i < 12; i++) sw_script.push_back(1'b1);
        for (int i = 0; i < 12; i++) sw_script.push_back(1'b0);
        run_instr(3'd5, 1'b1);
        chk("press_delay", 8'(w_cyc - rise_cyc), 8'd5);
        chk("release_delay", 8'(pc_cyc - fall_cyc), 8'd5);

        // Alternating glitch during WAIT_PRESS must not complete the press.
        for (int i = 0; i < 16; i++) sw_script.push_back(i[0] ? 1'b0 : 1'b1);
        for (int i = 0; i < 10; i++) sw_script.push_back(1'b1);
        for (int i = 0; i < 10; i++) sw_script.push_back(1'b0);
        run_instr(3'd5, 1'b1);
        chk("glitch_ignored", 8'(w_cyc - rise_cyc), 8'd5);

        // Branch and IN without handshake.
        run_instr(3'd6, 1'b0);
        run_instr(3'd5, 1'b0);
        run_instr(3'd0, 1'b0);

`ifdef STEP_MODE_EN
        // No step: FETCH holds and the PC never advances.
        opcode = 3'd0;
        step   = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("step_idle", outs, 8'h00);
        end
        run_instr(3'd0, 1'b0);
`endif

        // Randomized instruction stream with switch activity.
        rand_sw = 1'b1;
        for (int i = 0; i < 80; i++) begin
            run_instr(3'($urandom_range(6)), 1'($urandom_range(1)));
        end

        // HALT is absorbing regardless of switch activity.
        run_instr(3'd7, 1'b0);
        for (int i = 0; i < 20; i++) begin
            sw_raw = 1'($urandom_range(1));
            tick();
            chk("halt_hold", outs, B_HALT);
        end
        reset = 1'b0;
        #1;
        chk("rst_from_halt", outs, 8'h00);
        #1;
        reset = 1'b1;
        model_reset();
        run_instr(3'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control FSM for the picoMIPS datapath; replaces the purely combinational decoder/PCincr path.
- Each instruction is sequenced as FETCH then EXEC, plus switch-handshake wait states and a terminal HALT.
- Drives PC enable/branch, register write, ALU/mux selects and the LED latch load.
- Sits between the program ROM opcode field and the pc, regs, alu and LED register.

Parameters:
- DB_CYCLES, 3, consecutive synchronised samples required before the debounced switch changes state (clock is about 10 Hz).
- DB_W, 2, width of the debounce counter; must hold DB_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  3  instruction bits [14:12].
- hold_en  input  1  instruction bit [7]; on IN, wait for the switch handshake.
- sw_raw  input  1  raw SW[8] push switch, asynchronous to clk.
- pc_en  output  1  PC advances by one at the next clk edge.
- pc_branch  output  1  PC loads the branch address at the next clk edge.
- w  output  1  register file write enable.
- write_select  output  1  1 selects SW[7:0] as write data; 0 selects the ALU result.
- imm  output  1  ALU port B takes the instruction immediate.
- func  output  1  ALU function: 0 = add, 1 = multiply.
- led_load  output  1  LED register captures the ALU result.
- halted  output  1  FSM is in HALT.

Behaviour:
- Opcode map:
  - 000 NOP; 001 ADD; 010 ADDI (also loads LED); 011 MUL; 100 MULI.
  - 101 IN (register write from the switches); 110 BR (absolute branch); 111 HALT.
- States: FETCH, EXEC, WAIT_PRESS, WAIT_RELEASE, HALT.
- Reset:
  - State = FETCH.
  - Synchroniser and debounced switch = 0; debounce counter = 0.
  - All outputs 0.
- Output timing: all outputs are registered-state decodes, i.e. Moore outputs plus decode of the held opcode. They are valid only in the states listed; 0 elsewhere.
- FETCH:
  - Lasts one cycle; ROM settles; no outputs asserted.
  - Goes to HALT if opcode = 111, else to EXEC.
- EXEC (one cycle):
  - ALU ops 001–100: w = 1; pc_en = 1.
  - func = 1 for 011 and 100; imm = 1 for 010 and 100.
  - ADDI additionally asserts led_load.
  - NOP: pc_en only.
  - BR: pc_branch = 1 and pc_en = 0.
  - IN with hold_en = 0: w = 1, write_select = 1, pc_en = 1.
  - IN with hold_en = 1: no outputs; go to WAIT_PRESS.
  - All other cases return to FETCH.
- WAIT_PRESS:
  - Stays while the debounced switch is 0.
  - On the first cycle the debounced switch is 1: w = 1 and write_select = 1 (single pulse), then go to WAIT_RELEASE.
- WAIT_RELEASE:
  - Stays while the debounced switch is 1.
  - When it is 0: pc_en = 1 for one cycle, then go to FETCH.
- Instruction length:
  - Exactly 2 cycles for non-wait instructions.
  - Wait instructions take 2 cycles plus the press and release durations.
- Synchroniser and debounce:
  - sw_raw passes through a 2-flop synchroniser.
  - The debounced value flips only after DB_CYCLES consecutive synchronised samples that differ from it.
  - Any matching sample clears the counter.
  - A switch held high before WAIT_PRESS is entered completes the press immediately on the first WAIT_PRESS cycle; no edge is required.
- HALT:
  - Absorbing; halted = 1; all other outputs 0.
  - Left only via reset.
- Output exclusivity:
  - pc_en and pc_branch are never both 1.
  - w is asserted at most once per instruction.
- Reset mid-operation (including WAIT states): returns to FETCH immediately and asynchronously; outputs drop to 0 in the same instant.
- The opcode must be stable from FETCH through instruction completion. The FSM does not latch it; the PC does not change in those cycles.

Optional Feature:
- Macro STEP_MODE_EN.
- When defined:
  - Adds input port step (1 bit, raw push button).
  - step gets its own 2-flop synchroniser and DB_CYCLES debounce.
  - FETCH stays in FETCH until a debounced rising edge of step is seen, then proceeds as normal.
  - Gives single-instruction stepping.
- When undefined: no step port; FETCH always lasts one cycle.

Test Plan:
- Reset low mid-EXEC of ADD (w = 1) -> all outputs 0 at once; after release, FETCH, then EXEC w = 1, pc_en = 1 on the second cycle.
- Sequence ADDI, MULI, MUL -> EXEC outputs are, in order:
  - (w, imm, led_load, func) = (1, 1, 1, 0);
  - (1, 1, 0, 1);
  - (1, 0, 0, 1);
  - pc_en = 1 on each, with 2 cycles per instruction.
- IN with hold_en = 1, sw_raw held 0 for 10 cycles, then 1:
  - w stays 0 during the wait.
  - A single w/write_select pulse occurs 2 + 3 cycles after the rise.
  - No pc_en until sw_raw is 0 for 5 cycles; then exactly one pc_en pulse.
- sw_raw glitch 1-0-1-0 on alternate cycles during WAIT_PRESS -> debounced value never changes; no w pulse.
- BR -> pc_branch = 1 for 1 cycle, pc_en = 0; opcode 111 -> halted = 1 from the cycle after FETCH, persisting for 20 cycles under any sw_raw activity.
- STEP_MODE_EN: NOP sequence with no step -> stays in FETCH and pc_en never asserts; one step press -> exactly one pc_en pulse.
